// File: rtl/bist_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bist_sequencer_pkg
// Shared definitions for the BIST start/end sequencer:
//   - state_t  : FSM state encoding (3-bit, IDLE/START/WAIT/GAP/DONE)
//   - PASS     : polarity of the core's pass_fail pin (1 = pass)
//   - cnt_width: width of a down-counter that has to hold values up to max_val
// -----------------------------------------------------------------------------
package bist_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic PASS = 1'b1;

  // Never returns 0, so a counter built from it always has at least one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bist_cycle_timer.sv
// -----------------------------------------------------------------------------
// bist_cycle_timer
// Loadable down-counter used for fixed-length holds and as a watchdog.
// Loading value N makes 'expired' rise N cycles later and stay high until the
// next load. Load has priority over clear.
// Ports:
//   clk      in  1  clock, rising edge
//   rst      in  1  synchronous, active-high reset (count -> 0)
//   clear    in  1  force count to 0 (expired)
//   load     in  1  load load_val into the counter
//   load_val in  W  value to load
//   expired  out 1  count has reached zero
// -----------------------------------------------------------------------------
module bist_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // NOTE: flops are written with <= so every register samples pre-edge values,
  // independent of the order in which always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/bist_sequencer.sv
// -----------------------------------------------------------------------------
// bist_sequencer
// Initiator side of the BIST start/end handshake. A campaign request issues
// num_runs bist_start pulses to the core, waits for a rising edge of bist_end
// after each one, samples pass_fail on that edge and accumulates pass/fail
// counts. A one-cycle done pulse marks campaign completion.
//
// Optional feature: define BIST_TIMEOUT_EN to build a per-run watchdog. A run
// that sees no bist_end edge within TIMEOUT_CYC cycles counts as a fail and
// sets the sticky timeout_err. Without the macro WAIT waits indefinitely and
// timeout_err is tied to 0.
//
// Ports:
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous, active-high reset
//   req         in   1      campaign request, sampled only in IDLE
//   num_runs    in   RUN_W  runs per campaign, captured on accept
//   bist_start  out  1      to core: high for START_HOLD cycles per run
//   bist_end    in   1      from core: run finished (rising edge used)
//   pass_fail   in   1      from core: 1 = pass, valid while bist_end=1
//   busy        out  1      campaign in progress
//   done        out  1      one-cycle pulse at campaign completion
//   all_pass    out  1      no failing run in the last campaign
//   pass_count  out  RUN_W  runs reported pass
//   fail_count  out  RUN_W  runs reported fail (or timed out)
//   timeout_err out  1      sticky: a run timed out in this campaign
// -----------------------------------------------------------------------------
module bist_sequencer
  import bist_sequencer_pkg::*;
#(
  parameter int START_HOLD = 10,
  parameter int GAP_CYC    = 4,
  parameter int RUN_W      = 8
`ifdef BIST_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [RUN_W-1:0] num_runs,
  output logic             bist_start,
  input  logic             bist_end,
  input  logic             pass_fail,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [RUN_W-1:0] pass_count,
  output logic [RUN_W-1:0] fail_count,
  output logic             timeout_err
);

  // One timer serves both the START hold and the GAP hold; they never overlap.
  localparam int HOLD_MAX = (START_HOLD > GAP_CYC) ? START_HOLD : GAP_CYC;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);
  localparam logic [HOLD_W-1:0] START_LOAD = HOLD_W'(START_HOLD - 1);
  localparam logic [HOLD_W-1:0] GAP_LOAD   = HOLD_W'(GAP_CYC - 1);

  state_t            state, state_next;
  logic              bist_end_q;
  logic              end_rise;
  logic [RUN_W-1:0]  num_runs_q;
  logic [RUN_W:0]    run_idx;
  logic [RUN_W:0]    run_idx_inc;
  logic              all_pass_q;
  logic              bist_start_q;

  logic              accept;
  logic              run_end;
  logic              run_pass;
  logic              hold_load;
  logic [HOLD_W-1:0] hold_val;
  logic              hold_expired;

`ifdef BIST_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  logic wd_load;
  logic wd_expired;
  logic run_timeout;
  logic timeout_err_q;
`endif

  // Only a fresh rising edge completes a run; a level left high from an
  // earlier run keeps end_rise low until the core drops and re-raises it.
  assign end_rise    = bist_end & ~bist_end_q;
  assign run_idx_inc = run_idx + (RUN_W + 1)'(1);

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    run_end    = 1'b0;
    run_pass   = 1'b0;
    hold_load  = 1'b0;
    hold_val   = START_LOAD;
`ifdef BIST_TIMEOUT_EN
    wd_load     = 1'b0;
    run_timeout = 1'b0;
`endif

    unique case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (num_runs == '0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_START;
            hold_load  = 1'b1;
            hold_val   = START_LOAD;
          end
        end
      end

      S_START: begin
        if (hold_expired) begin
          state_next = S_WAIT;
`ifdef BIST_TIMEOUT_EN
          wd_load = 1'b1;
`endif
        end
      end

      S_WAIT: begin
        // A real edge wins over a watchdog expiry in the same cycle.
        if (end_rise) begin
          run_end  = 1'b1;
          run_pass = (pass_fail == PASS);
        end
`ifdef BIST_TIMEOUT_EN
        else if (wd_expired) begin
          run_end     = 1'b1;
          run_timeout = 1'b1;
        end
`endif
        if (run_end) begin
          if (run_idx_inc == {1'b0, num_runs_q}) begin
            state_next = S_DONE;
          end else begin
            state_next = S_GAP;
            hold_load  = 1'b1;
            hold_val   = GAP_LOAD;
          end
        end
      end

      S_GAP: begin
        if (hold_expired) begin
          state_next = S_START;
          hold_load  = 1'b1;
          hold_val   = START_LOAD;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and campaign bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bist_end_q   <= 1'b0;
      bist_start_q <= 1'b0;
      num_runs_q   <= '0;
      run_idx      <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      all_pass_q   <= 1'b0;
    end else begin
      state      <= state_next;
      bist_end_q <= bist_end;
      // Registered so the pin to the core is driven straight from a flop.
      bist_start_q <= (state_next == S_START);

      if (accept) begin
        num_runs_q <= num_runs;
        run_idx    <= '0;
        pass_count <= '0;
        fail_count <= '0;
        all_pass_q <= 1'b0;
      end else if (run_end) begin
        run_idx <= run_idx_inc;
        if (run_pass) begin
          pass_count <= pass_count + RUN_W'(1);
        end else begin
          fail_count <= fail_count + RUN_W'(1);
        end
      end

      if (state == S_DONE) begin
        all_pass_q <= (fail_count == '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold timer (START / GAP lengths); idles at zero outside a campaign
  // ---------------------------------------------------------------------------
  bist_cycle_timer #(
    .W (HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == S_IDLE),
    .load     (hold_load),
    .load_val (hold_val),
    .expired  (hold_expired)
  );

`ifdef BIST_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // WAIT watchdog: reloaded on every entry to WAIT
  // ---------------------------------------------------------------------------
  bist_cycle_timer #(
    .W (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == S_IDLE),
    .load     (wd_load),
    .load_val (WD_LOAD),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (accept) begin
      timeout_err_q <= 1'b0;
    end else if (run_timeout) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bist_start = bist_start_q;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  // During the done pulse the counts are already final, so the verdict is
  // presented together with done and then held in all_pass_q.
  assign all_pass   = done ? (fail_count == '0) : all_pass_q;

endmodule
